div_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one non-restoring divider unit among up to NUM_REQ requesters. The block accepts one division request at a time and drives the divider's start pulse and operands. It collects quotient and remainder when the divider signals done and returns them with the requester ID through a valid/ready response port. It sits between the requesting blocks and the divider datapath/control pair, and also handles divide-by-zero bypass and a done-timeout watchdog.

---
 rtl/div_share_arbiter.sv | 168 ++++++++++++++++
 tb/tb_div_share_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// Round-robin front end that time-shares one divider among NUM_REQ requesters,
// with divide-by-zero bypass and a watchdog on the divider's done signal.
module div_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic                     div_done,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic [1:0]               rsp_status,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [WD_W-1:0]    wd_reg;
  logic               div_start_reg;
  logic [WIDTH-1:0]   div_dividend_reg;
  logic [WIDTH-1:0]   div_divisor_reg;
  logic               rsp_valid_reg;
  logic [ID_W-1:0]    rsp_id_reg;
  logic [WIDTH-1:0]   rsp_quotient_reg;
  logic [WIDTH-1:0]   rsp_remainder_reg;
  logic [1:0]         rsp_status_reg;
  logic               busy_reg;

  logic [PTR_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic [WIDTH-1:0]   gnt_dividend;
  logic [WIDTH-1:0]   gnt_divisor;

  // Offset gi from ptr maps to requester (ptr+gi) mod NUM_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [PTR_W:0] sum;
      assign sum = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                            PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : sum[PTR_W-1:0];
      assign cand_hit[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        gnt_idx   = cand_idx[k];
        gnt_found = 1'b1;
      end
    end
  end

  assign gnt_dividend = req_dividend[gnt_idx*WIDTH +: WIDTH];
  assign gnt_divisor  = req_divisor[gnt_idx*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (state_reg == S_IDLE && !rst && gnt_found)
      req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_IDLE;
      ptr_reg           <= '0;
      wd_reg            <= '0;
      div_start_reg     <= 1'b0;
      div_dividend_reg  <= '0;
      div_divisor_reg   <= '0;
      rsp_valid_reg     <= 1'b0;
      rsp_id_reg        <= '0;
      rsp_quotient_reg  <= '0;
      rsp_remainder_reg <= '0;
      rsp_status_reg    <= 2'b00;
      busy_reg          <= 1'b0;
    end else begin
      div_start_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (gnt_found) begin
            div_dividend_reg <= gnt_dividend;
            div_divisor_reg  <= gnt_divisor;
            rsp_id_reg       <= ID_W'(gnt_idx);
            ptr_reg          <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            busy_reg         <= 1'b1;
            if (gnt_divisor == '0) begin
              // Zero divisor never reaches the divider.
              rsp_quotient_reg  <= '1;
              rsp_remainder_reg <= gnt_dividend;
              rsp_status_reg    <= 2'b01;
              rsp_valid_reg     <= 1'b1;
              state_reg         <= S_RESP;
            end else begin
              div_start_reg <= 1'b1;
              state_reg     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wd_reg    <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            rsp_quotient_reg  <= div_quotient;
            rsp_remainder_reg <= div_remainder;
            rsp_status_reg    <= 2'b00;
            rsp_valid_reg     <= 1'b1;
            state_reg         <= S_RESP;
          end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
            rsp_quotient_reg  <= '0;
            rsp_remainder_reg <= '0;
            rsp_status_reg    <= 2'b10;
            rsp_valid_reg     <= 1'b1;
            state_reg         <= S_RESP;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign div_start     = div_start_reg;
  assign div_dividend  = div_dividend_reg;
  assign div_divisor   = div_divisor_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_id        = rsp_id_reg;
  assign rsp_quotient  = rsp_quotient_reg;
  assign rsp_remainder = rsp_remainder_reg;
  assign rsp_status    = rsp_status_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural divider stand-in
// whose latency and done behaviour are steered from the stimulus sequence.
module tb_div_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        div_start;
  logic [7:0]  div_dividend;
  logic [7:0]  div_divisor;
  logic        div_done;
  logic [7:0]  div_quotient;
  logic [7:0]  div_remainder;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_quotient;
  logic [7:0]  rsp_remainder;
  logic [1:0]  rsp_status;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  logic [7:0] model_lat;
  logic       model_en;
  logic       spurious_done;
  logic [7:0] mcnt;

  div_share_arbiter #(.WIDTH(8), .NUM_REQ(4), .ID_W(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_status(rsp_status), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider stand-in: done is high model_lat cycles after the start cycle.
  always @(posedge clk) begin
    if (rst) mcnt <= 8'd0;
    else if (div_start) mcnt <= 8'd1;
    else if (mcnt != 8'd0) mcnt <= (mcnt == model_lat) ? 8'd0 : mcnt + 8'd1;
  end
  assign div_done      = (model_en && mcnt != 8'd0 && mcnt == model_lat) || spurious_done;
  assign div_quotient  = (div_divisor != 8'd0) ? div_dividend / div_divisor : 8'd0;
  assign div_remainder = (div_divisor != 8'd0) ? div_dividend % div_divisor : 8'd0;

  always @(negedge clk) begin
    if (div_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] dd, input logic [7:0] dv);
    req_dividend[i*8 +: 8] = dd;
    req_divisor[i*8 +: 8]  = dv;
  endtask

  // Called #1 after a negedge in the grant cycle T with req_valid already driven.
  task automatic txn(input string tag, input logic [3:0] gnt, input logic [1:0] id,
                     input logic [7:0] q, input logic [7:0] r, input logic [1:0] st,
                     input int lat, input int starts, input bit drop, input int hold);
    int s0;
    int n;
    s0 = start_cnt;
    check({tag, ".gnt"}, {28'd0, req_ready}, {28'd0, gnt});
    @(negedge clk);
    if (drop) req_valid = req_valid & ~gnt;
    #1;
    check({tag, ".rdy_once"}, {28'd0, req_ready}, 32'd0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, n, lat);
    check({tag, ".rsp"}, {19'd0, busy, rsp_id, rsp_quotient, rsp_remainder, rsp_status},
          {19'd0, 1'b1, id, q, r, st});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check({tag, ".hold"},
            {7'd0, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_status, req_ready},
            {7'd0, 1'b1, id, q, r, st, 4'b0000});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check({tag, ".idle"}, {30'd0, rsp_valid, busy}, 32'd0);
    check({tag, ".starts"}, start_cnt - s0, starts);
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b0; req_dividend = '0; req_divisor = '0;
    rsp_ready = 1'b0; model_lat = 8'd10; model_en = 1'b1; spurious_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.req_ready", {28'd0, req_ready}, 32'd0);
    check("rst.div", {15'd0, div_start, div_dividend, div_divisor}, 32'd0);
    check("rst.rsp", {11'd0, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_status}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Single request from requester 1: 100/7, divider latency 10.
    set_op(1, 8'd100, 8'd7);
    req_valid = 4'b0010;
    #1;
    txn("single", 4'b0010, 2'd1, 8'd14, 8'd2, 2'b00, 11, 1, 1'b1, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // All four valid continuously: grants 0,1,2,3 then wrap to 0.
    model_lat = 8'd3;
    set_op(0, 8'd50, 8'd5);
    set_op(1, 8'd77, 8'd8);
    set_op(2, 8'd200, 8'd9);
    set_op(3, 8'd255, 8'd16);
    req_valid = 4'b1111;
    #1;
    txn("rr0", 4'b0001, 2'd0, 8'd10, 8'd0, 2'b00, 4, 1, 1'b0, 0);
    txn("rr1", 4'b0010, 2'd1, 8'd9, 8'd5, 2'b00, 4, 1, 1'b0, 0);
    txn("rr2", 4'b0100, 2'd2, 8'd22, 8'd2, 2'b00, 4, 1, 1'b0, 0);
    txn("rr3", 4'b1000, 2'd3, 8'd15, 8'd15, 2'b00, 4, 1, 1'b0, 0);
    txn("rr4", 4'b0001, 2'd0, 8'd10, 8'd0, 2'b00, 4, 1, 1'b0, 0);
    req_valid = 4'b0000;

    // Divide by zero from requester 2: bypass, no start.
    set_op(2, 8'h5A, 8'h00);
    req_valid = 4'b0100;
    #1;
    txn("dbz", 4'b0100, 2'd2, 8'hFF, 8'h5A, 2'b01, 0, 0, 1'b1, 0);

    // Response held 5 cycles with requester 1 pending; it is granted right after.
    set_op(0, 8'd45, 8'd6);
    set_op(1, 8'd130, 8'd11);
    req_valid = 4'b0011;
    #1;
    txn("hold", 4'b0001, 2'd0, 8'd7, 8'd3, 2'b00, 4, 1, 1'b1, 5);
    txn("after_hold", 4'b0010, 2'd1, 8'd11, 8'd9, 2'b00, 4, 1, 1'b1, 0);

    // Divider never answers: watchdog fires TIMEOUT+2 cycles after grant.
    model_en = 1'b0;
    set_op(3, 8'd9, 8'd3);
    req_valid = 4'b1000;
    #1;
    txn("timeout", 4'b1000, 2'd3, 8'd0, 8'd0, 2'b10, 65, 1, 1'b1, 0);
    model_en = 1'b1;
    set_op(0, 8'd64, 8'd10);
    req_valid = 4'b0001;
    #1;
    txn("post_to", 4'b0001, 2'd0, 8'd6, 8'd4, 2'b00, 4, 1, 1'b1, 0);

    // Reset while waiting on the divider, then a stray done while idle.
    model_lat = 8'd20;
    set_op(2, 8'd99, 8'd4);
    req_valid = 4'b0100;
    #1;
    check("midrst.gnt", {28'd0, req_ready}, 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    check("midrst.busy_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.after", {30'd0, busy, rsp_valid}, 32'd0);
    spurious_done = 1'b1;
    @(negedge clk);
    spurious_done = 1'b0;
    @(negedge clk);
    check("midrst.spurious", {29'd0, busy, rsp_valid, div_start}, 32'd0);
    model_lat = 8'd3;
    set_op(0, 8'd250, 8'd7);
    set_op(3, 8'd12, 8'd3);
    req_valid = 4'b1001;
    #1;
    txn("midrst.next", 4'b0001, 2'd0, 8'd35, 8'd5, 2'b00, 4, 1, 1'b1, 0);
    req_valid = 4'b0000;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
